ft232h_rx: RTL and testbench

- Receive engine for the FT232H synchronous 245 FIFO interface; drains bytes from the chip's RX FIFO (RXF#/OE#/RD#) into a local first-word-fall-through buffer.
- Presents the buffered bytes as a valid/ready byte stream.
- Runs entirely in the FT232H 60 MHz CLKOUT domain; the crossing to the Avalon domain is handled downstream by the existing dual-clock fifo.
- Shares the data bus with the transmit path: yields when tx_req is asserted and advertises bus ownership on rx_busy.

---
 rtl/ft232h_rx_if.sv | 27 ++
 rtl/ft232h_rx.sv | 193 +++++++++++++++++++
 tb/tb_ft232h_rx.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft232h_rx_if.sv
// ft232h_rx_if: byte stream carrying bytes out of the ft232h_rx receive buffer.
//
// Handshake: m_data is meaningful whenever m_valid is high. A byte moves on
// every rising clk edge where m_valid && m_ready. A master holding m_valid
// keeps m_data stable until that byte is taken. m_ready may change freely.
//
// Signals:
//   m_data  [7:0]  byte at the head of the buffer   (master -> slave)
//   m_valid        head byte present                (master -> slave)
//   m_ready        consumer takes the byte now      (slave  -> master)
interface ft232h_rx_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/ft232h_rx.sv
// ft232h_rx: receive engine for the FT232H synchronous 245 FIFO interface.
// It bursts bytes out of the chip RX FIFO (RXF#/OE#/RD#) into a local
// first-word-fall-through buffer. The buffer drains as a valid/ready stream.
// All logic runs in the FT232H CLKOUT (60 MHz) domain.
//
// Optional build macro: FT232H_RX_STATS_EN adds the rx_byte_count and
// rx_burst_count statistics outputs.
//
// Ports:
//   clk            FT232H CLKOUT
//   rst            synchronous, active-high reset
//   ft_data_in     D[7:0] input path; the top level owns the tristate
//   ft_rxf_n       RXF#, low while the chip holds RX data
//   ft_oe_n        OE#, registered
//   ft_rd_n        RD#, registered
//   tx_req         transmit path asks for the shared bus
//   rx_busy        high while the bus belongs to this block (state != IDLE)
//   m_if           outgoing byte stream (master modport)
//   level          buffer occupancy, 0..DEPTH
//   rx_byte_count  (stats build) captured bytes, wraps at 2^32
//   rx_burst_count (stats build) bursts started, wraps at 2^16
//   dbg_state_o    FSM state: 0 IDLE, 1 TURN, 2 READ, 3 RELEASE
module ft232h_rx #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int MIN_FREE  = 4,
  parameter int MAX_BURST = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ft_data_in,
  input  logic              ft_rxf_n,
  output logic              ft_oe_n,
  output logic              ft_rd_n,
  input  logic              tx_req,
  output logic              rx_busy,
  ft232h_rx_if.master       m_if,
  output logic [ADDR_W:0]   level,
`ifdef FT232H_RX_STATS_EN
  output logic [31:0]       rx_byte_count,
  output logic [15:0]       rx_burst_count,
`endif
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TURN    = 2'd1,
    READ    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] MIN_FREE_L = (ADDR_W+1)'(MIN_FREE);
  localparam logic [15:0]     MAX_L      = 16'(MAX_BURST);

  state_t              state_q;
  logic                oe_n_q;
  logic                rd_n_q;
  logic                busy_q;
  logic [15:0]         burst_q;

  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;

  logic                capture;
  logic                pop;
  logic [ADDR_W:0]     free;
  logic [15:0]         burst_inc;
  logic                last_slot;
  logic                start_burst;

  // RD# is only low in READ, so the registered RD# alone identifies a read
  // edge; RXF# is chip-synchronous and is used raw.
  assign capture     = !rd_n_q && !ft_rxf_n;
  assign pop         = (level_q != '0) && m_if.m_ready;
  assign free        = DEPTH_L - level_q;
  assign burst_inc   = burst_q + 16'(capture);
  // A pop at the same edge is ignored here: stopping one byte early is
  // always safe, and it keeps the exit decision independent of the consumer.
  assign last_slot   = capture && (free == (ADDR_W+1)'(1));
  // tx_req has priority over a new receive burst.
  assign start_burst = (state_q == IDLE) && !ft_rxf_n && (free >= MIN_FREE_L) && !tx_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      oe_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_burst) begin
            state_q <= TURN;
            oe_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            burst_q <= '0;
          end
        end
        TURN: begin
          // One cycle with OE# low and RD# high lets the chip take the bus.
          state_q <= READ;
          rd_n_q  <= 1'b0;
        end
        READ: begin
          burst_q <= burst_inc;
          if (ft_rxf_n || last_slot || (tx_req && (burst_inc >= MAX_L))) begin
            state_q <= RELEASE;
            rd_n_q  <= 1'b1;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
          oe_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          oe_n_q  <= 1'b1;
          rd_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(capture);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    level_d  = level_q;
    unique case ({capture, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; level_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= ft_data_in;
    end
  end

`ifdef FT232H_RX_STATS_EN
  logic [31:0] byte_cnt_q;
  logic [15:0] burst_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (capture) begin
        byte_cnt_q <= byte_cnt_q + 32'd1;
      end
      if (start_burst) begin
        burst_cnt_q <= burst_cnt_q + 16'd1;
      end
    end
  end

  assign rx_byte_count  = byte_cnt_q;
  assign rx_burst_count = burst_cnt_q;
`else
  // Statistics counters are not built.
`endif

  assign ft_oe_n      = oe_n_q;
  assign ft_rd_n      = rd_n_q;
  assign rx_busy      = busy_q;
  assign m_if.m_data  = mem_q[rd_ptr_q];
  assign m_if.m_valid = (level_q != '0);
  assign level        = level_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ft232h_rx.sv
// tb_ft232h_rx: directed bench for ft232h_rx (DEPTH=16, MIN_FREE=4,
// MAX_BURST=8). A small FT232H model presents queued bytes on D[7:0] with
// RXF# low while it has data, and advances one byte on each edge where RD#
// and RXF# are both low. Every byte loaded into the chip is also queued as
// the expected stream; popped bytes are checked against that queue in order.
module tb_ft232h_rx;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TURN = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic              clk;
  logic              rst;
  logic [7:0]        ft_data_in;
  logic              ft_rxf_n;
  logic              ft_oe_n;
  logic              ft_rd_n;
  logic              tx_req;
  logic              rx_busy;
  logic [ADDR_W:0]   level;
  logic [1:0]        dbg_state;
`ifdef FT232H_RX_STATS_EN
  logic [31:0]       rx_byte_count;
  logic [15:0]       rx_burst_count;
`endif

  ft232h_rx_if sif ();

  ft232h_rx #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MIN_FREE(4), .MAX_BURST(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ft_data_in(ft_data_in),
    .ft_rxf_n(ft_rxf_n),
    .ft_oe_n(ft_oe_n),
    .ft_rd_n(ft_rd_n),
    .tx_req(tx_req),
    .rx_busy(rx_busy),
    .m_if(sif.master),
    .level(level),
`ifdef FT232H_RX_STATS_EN
    .rx_byte_count(rx_byte_count),
    .rx_burst_count(rx_burst_count),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / chip model state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] chip_q[$];
  bit         rxf_block;
  int         n_caps;
  int         total;
  int         bad;

  task automatic drive_chip();
    ft_data_in = (chip_q.size() != 0) ? chip_q[0] : 8'h00;
    ft_rxf_n   = (chip_q.size() == 0) || rxf_block;
  endtask

  task automatic load_chip(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      chip_q.push_back(first + 8'(i));
      exp_q.push_back(first + 8'(i));
    end
    drive_chip();
  endtask

  // One clock: checks pops and hold stability, then advances the chip.
  task automatic tick();
    bit         cap;
    bit         pop;
    bit         hold;
    logic [7:0] hold_data;
    logic [7:0] exp;
    cap       = (ft_rd_n === 1'b0) && (ft_rxf_n === 1'b0);
    pop       = (sif.m_valid === 1'b1) && (sif.m_ready === 1'b1);
    hold      = (sif.m_valid === 1'b1) && (sif.m_ready === 1'b0);
    hold_data = sif.m_data;
    if (pop) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_order: popped %02h, required no byte", sif.m_data);
      end else begin
        exp = exp_q.pop_front();
        if (sif.m_data !== exp) begin
          bad++;
          $display("FAIL pop_order: got %02h, required %02h", sif.m_data, exp);
        end
      end
    end
    @(posedge clk);
    #1;
    if (hold && sif.m_valid === 1'b1) begin
      total++;
      if (sif.m_data !== hold_data) begin
        bad++;
        $display("FAIL hold_stable: m_data %02h, required %02h", sif.m_data, hold_data);
      end
    end
    if (cap && !rst) begin
      chip_q.delete(0);
      n_caps++;
    end
    drive_chip();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chip_q.delete();
    exp_q.delete();
    rxf_block = 1'b0;
    drive_chip();
  endtask

  task automatic run_until_drained(input string name, input int budget);
    int b;
    b = budget;
    sif.m_ready = 1'b1;
    while ((exp_q.size() != 0 || chip_q.size() != 0 || dbg_state != S_IDLE) && b > 0) begin
      tick();
      b--;
    end
    total++;
    if (b == 0) begin
      bad++;
      $display("FAIL %s_drain: timed out, %0d bytes undelivered, required 0", name, exp_q.size());
    end
    total++;
    if (level !== '0) begin
      bad++;
      $display("FAIL %s_level: level %0d, required 0", name, level);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if ({ft_oe_n, ft_rd_n, rx_busy, sif.m_valid} !== 4'b1100 || level !== '0 || dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL reset_values: oe_n=%b rd_n=%b busy=%b valid=%b level=%0d state=%0d, required 1 1 0 0 0 0",
               ft_oe_n, ft_rd_n, rx_busy, sif.m_valid, level, dbg_state);
    end
  endtask

  task automatic test_basic_burst();
    int turn_cyc;
    int rel_cyc;
    do_reset();
    n_caps = 0;
    turn_cyc = 0;
    rel_cyc = 0;
    sif.m_ready = 1'b1;
    load_chip(8'h10, 5);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dbg_state == S_TURN) turn_cyc++;
      if (dbg_state == S_REL) rel_cyc++;
      if (dbg_state == S_TURN && (ft_oe_n !== 1'b0 || ft_rd_n !== 1'b1 || rx_busy !== 1'b1)) begin
        total++;
        bad++;
        $display("FAIL basic_turn_pins: oe_n=%b rd_n=%b busy=%b, required 0 1 1", ft_oe_n, ft_rd_n, rx_busy);
      end
    end
    total++;
    if (n_caps != 5) begin
      bad++;
      $display("FAIL basic_caps: %0d captured, required 5", n_caps);
    end
    total++;
    if (turn_cyc != 1 || rel_cyc != 1) begin
      bad++;
      $display("FAIL basic_phases: turn=%0d release=%0d cycles, required 1 1", turn_cyc, rel_cyc);
    end
    total++;
    if (ft_oe_n !== 1'b1 || rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle_pins: oe_n=%b busy=%b, required 1 0", ft_oe_n, rx_busy);
    end
    run_until_drained("basic", 50);
  endtask

  task automatic test_full_buffer();
    int b;
    do_reset();
    n_caps = 0;
    sif.m_ready = 1'b0;
    load_chip(8'h20, 24);
    b = 60;
    while (n_caps < 16 && b > 0) begin
      tick();
      b--;
    end
    total++;
    if (ft_rd_n !== 1'b1 || dbg_state !== S_REL) begin
      bad++;
      $display("FAIL full_exit: rd_n=%b state=%0d after 16th capture, required 1 3", ft_rd_n, dbg_state);
    end
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (n_caps != 16 || level !== 5'd16 || dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL full_hold: caps=%0d level=%0d state=%0d, required 16 16 0", n_caps, level, dbg_state);
    end
    total++;
    if (sif.m_data !== 8'h20) begin
      bad++;
      $display("FAIL full_head: m_data %02h, required 20", sif.m_data);
    end
    sif.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    sif.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (level !== 5'd13 || n_caps != 16 || dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL full_no_restart: level=%0d caps=%0d state=%0d, required 13 16 0", level, n_caps, dbg_state);
    end
    sif.m_ready = 1'b1;
    tick();
    sif.m_ready = 1'b0;
    total++;
    if (level !== 5'd12 || dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL full_pop4: level=%0d state=%0d, required 12 0", level, dbg_state);
    end
    tick();
    total++;
    if (dbg_state !== S_TURN) begin
      bad++;
      $display("FAIL full_restart: state=%0d, required 1", dbg_state);
    end
    run_until_drained("full", 200);
    total++;
    if (n_caps != 24) begin
      bad++;
      $display("FAIL full_total: %0d captured, required 24", n_caps);
    end
  endtask

  task automatic test_tx_yield();
    int  b;
    bit  saw_turn;
    do_reset();
    n_caps = 0;
    sif.m_ready = 1'b1;
    load_chip(8'h40, 20);
    b = 10;
    while (dbg_state != S_READ && b > 0) begin
      tick();
      b--;
    end
    tx_req = 1'b1;
    b = 40;
    while (dbg_state == S_READ && b > 0) begin
      tick();
      b--;
    end
    total++;
    if (n_caps != 8 || dbg_state !== S_REL) begin
      bad++;
      $display("FAIL tx_burst_len: caps=%0d state=%0d, required 8 3", n_caps, dbg_state);
    end
    saw_turn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dbg_state != S_IDLE && i > 0) saw_turn = 1'b1;
    end
    total++;
    if (saw_turn || dbg_state !== S_IDLE || rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL tx_priority: left IDLE=%0d state=%0d busy=%b, required 0 0 0", saw_turn, dbg_state, rx_busy);
    end
    tx_req = 1'b0;
    tick();
    total++;
    if (dbg_state !== S_TURN) begin
      bad++;
      $display("FAIL tx_restart: state=%0d, required 1", dbg_state);
    end
    run_until_drained("tx", 100);
  endtask

  task automatic test_rxf_gap();
    int b;
    do_reset();
    n_caps = 0;
    sif.m_ready = 1'b1;
    load_chip(8'h60, 10);
    b = 20;
    while (n_caps < 3 && b > 0) begin
      tick();
      b--;
    end
    rxf_block = 1'b1;
    drive_chip();
    tick();
    total++;
    if (n_caps != 3 || dbg_state !== S_REL) begin
      bad++;
      $display("FAIL gap_exit: caps=%0d state=%0d, required 3 3", n_caps, dbg_state);
    end
    rxf_block = 1'b0;
    drive_chip();
    run_until_drained("gap", 60);
    total++;
    if (n_caps != 10) begin
      bad++;
      $display("FAIL gap_total: %0d captured, required 10", n_caps);
    end
  endtask

  task automatic test_reset_mid_burst();
    int b;
    do_reset();
    n_caps = 0;
    sif.m_ready = 1'b0;
    load_chip(8'h80, 8);
    b = 20;
    while (n_caps < 3 && b > 0) begin
      tick();
      b--;
    end
    rst = 1'b1;
    tick();
    total++;
    if ({ft_oe_n, ft_rd_n, sif.m_valid} !== 3'b110 || level !== '0 || dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL rst_mid: oe_n=%b rd_n=%b valid=%b level=%0d state=%0d, required 1 1 0 0 0",
               ft_oe_n, ft_rd_n, sif.m_valid, level, dbg_state);
    end
    rst = 1'b0;
    chip_q.delete();
    exp_q.delete();
    drive_chip();
  endtask

`ifdef FT232H_RX_STATS_EN
  task automatic test_stats();
    do_reset();
    load_chip(8'hA0, 4);
    run_until_drained("stats4", 60);
    load_chip(8'hB0, 7);
    run_until_drained("stats7", 60);
    load_chip(8'hC0, 1);
    run_until_drained("stats1", 60);
    total++;
    if (rx_byte_count !== 32'd12 || rx_burst_count !== 16'd3) begin
      bad++;
      $display("FAIL stats_counts: bytes=%0d bursts=%0d, required 12 3", rx_byte_count, rx_burst_count);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    n_caps = 0;
    rxf_block = 1'b0;
    rst = 1'b1;
    tx_req = 1'b0;
    sif.m_ready = 1'b0;
    drive_chip();
    test_reset();
    test_basic_burst();
    test_full_buffer();
    test_tx_yield();
    test_rxf_gap();
    test_reset_mid_burst();
`ifdef FT232H_RX_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
